link_ddr_downstream_unpack: RTL and testbench
=============================================

LINK_DDR_DOWNSTREAM_UNPACK -- requirements
Module: link_ddr_downstream_unpack

Interface
REQ-001 SHALL have parameter channel_width_p, default 16: bits per received io sample, which is one DDR pair already de-skewed.
REQ-002 SHALL have parameter fifo_els_p, default 8: word-buffer depth; must be a power of 2 and at least 2.
REQ-003 SHALL have parameter lg_credit_to_token_decimation_p, default 2: one token toggle per 2^p words consumed.
REQ-004 SHALL have io_clk_i  input  1: the single clock; all state is updated on its rising edge.
REQ-005 SHALL have io_link_reset_ni  input  1: asynchronous, active-low reset.
REQ-006 SHALL have io_valid_i  input  1: a sample is present this cycle.
REQ-007 SHALL have io_data_i  input  channel_width_p: the sample data.
REQ-008 SHALL have core_valid_o  output  1: the buffer holds at least one word.
REQ-009 SHALL have core_data_o  output  2*channel_width_p: the head word.
REQ-010 SHALL have core_yumi_i  input  1: the core consumes the head word this cycle.
REQ-011 SHALL have token_o  output  1: credit return to the upstream sender, signalled by toggling.
REQ-012 SHALL have overflow_o  output  1: sticky error flag, set when a word is dropped.

Function
REQ-013 SHALL pack samples with a phase bit:
- phase 0: a valid sample is stored in the low-half register and phase becomes 1.
- phase 1: a valid sample forms the word {io_data_i, low_r} and phase becomes 0.
REQ-014 SHALL hold phase and low_r unchanged on cycles with io_valid_i=0, so idle gaps between the two halves are legal.
REQ-015 SHALL write the completed word into the FIFO on the same edge that samples the second half; core_valid_o rises in the following cycle (latency 1 cycle from the second half).
REQ-016 SHALL drive core_valid_o = (count != 0) and core_data_o = FIFO head, both combinationally from registers and with no dependence on core_yumi_i.
REQ-017 SHALL, on core_yumi_i=1 with core_valid_o=1, advance the read pointer and decrement count on that edge.
REQ-018 SHALL ignore core_yumi_i=1 when the FIFO is empty: no pointer, count or token change.
REQ-019 SHALL keep read and write pointers log2(fifo_els_p) bits wide, wrapping modulo fifo_els_p; count is log2(fifo_els_p)+1 bits wide, range 0..fifo_els_p.
REQ-020 SHALL handle push and pop in the same cycle as follows:
- both accepted, count unchanged.
- this includes the full case, because the pop frees the slot first.
REQ-021 SHALL drop a push arriving when count==fifo_els_p with no simultaneous pop:
- no state other than phase changes.
- overflow_o is set to 1 and stays 1 until reset.
REQ-022 SHALL count accepted pops in a counter of lg_credit_to_token_decimation_p bits; on the pop that wraps it from all-ones to 0, token_o toggles on that edge.
REQ-023 SHALL, when lg_credit_to_token_decimation_p=0, toggle token_o on every accepted pop.
REQ-024 SHALL never produce X on any output when inputs are known; FIFO storage contents need not be reset.

Reset
REQ-025 SHALL, on io_link_reset_ni=0 and immediately (asynchronously), clear:
- phase, pointers, count and the token counter;
- core_valid_o=0, token_o=0, overflow_o=0.
REQ-026 SHALL discard a half-packed word and all buffered words when reset is asserted mid-operation; after release, the first valid sample is treated as a low half.
REQ-027 SHALL ignore io_valid_i and core_yumi_i while in reset; operation starts on the first rising edge after reset deassertion.

Verification
REQ-028 Basic packing: samples 0x1111 then 0x2222 on consecutive cycles with yumi=0 -> core_valid_o=1 in the next cycle, core_data_o=0x22221111.
REQ-029 Gapped halves: sample 0xAAAA, three idle cycles, then 0xBBBB -> single word 0xBBBBAAAA; core_valid_o stays 0 until the cycle after 0xBBBB.
REQ-030 Fill and overflow: 9 words pushed with yumi=0 (depth 8) -> count=8; the 9th is dropped and overflow_o=1; popping 8 words then returns words 1..8 in order.
REQ-031 Full with simultaneous push and pop:
- stimulus: FIFO full, yumi=1 in the same cycle a second half arrives.
- response: count stays 8, overflow_o stays 0, and the new word is read out 8th after that pop.
REQ-032 Token decimation (p=2): 8 accepted pops -> token_o toggles exactly twice, on the 4th and 8th pop edges; yumi pulses while empty cause no toggle.
REQ-033 Reset mid-word:
- stimulus: low half 0x1234 captured, reset pulsed low for 1 cycle, then 0x5555, 0x6666.
- response: after reset all outputs are 0; the next word is 0x66665555.

Source files
------------

// File: rtl/link_ddr_downstream_unpack_if.sv
// Sample-side and core-side signals of the DDR downstream unpacker.
// The io side pushes samples in; the core side drains words and gets token/overflow status.
interface link_ddr_downstream_unpack_if #(
    parameter int unsigned channel_width_p = 16
);
    logic                           io_valid_i;
    logic [channel_width_p-1:0]     io_data_i;
    logic                           core_valid_o;
    logic [2*channel_width_p-1:0]   core_data_o;
    logic                           core_yumi_i;
    logic                           token_o;
    logic                           overflow_o;

    // Sender / consumer side
    modport master (
        output io_valid_i,
        output io_data_i,
        output core_yumi_i,
        input  core_valid_o,
        input  core_data_o,
        input  token_o,
        input  overflow_o
    );

    // Unpacker side
    modport slave (
        input  io_valid_i,
        input  io_data_i,
        input  core_yumi_i,
        output core_valid_o,
        output core_data_o,
        output token_o,
        output overflow_o
    );
endinterface

// File: rtl/link_ddr_downstream_unpack.sv
// Packs pairs of received io samples into double-width words, buffers them in a
// small FIFO for the core, and returns decimated credits to the sender as token toggles.
module link_ddr_downstream_unpack #(
    parameter int unsigned channel_width_p                 = 16,
    parameter int unsigned fifo_els_p                      = 8,
    parameter int unsigned lg_credit_to_token_decimation_p = 2
) (
    input  logic                          io_clk_i,
    input  logic                          io_link_reset_ni,
    link_ddr_downstream_unpack_if.slave   link_if
);

    localparam int unsigned word_w = 2 * channel_width_p;
    localparam int unsigned ptr_w  = $clog2(fifo_els_p);
    localparam int unsigned cnt_w  = ptr_w + 1;
    localparam int unsigned tok_w  = (lg_credit_to_token_decimation_p == 0) ? 1
                                     : lg_credit_to_token_decimation_p;
    localparam bit          tok_every_pop = (lg_credit_to_token_decimation_p == 0);

    localparam logic [cnt_w-1:0] cnt_full = cnt_w'(fifo_els_p);

    // Packing phase: which half the next valid sample fills
    localparam logic [0:0] phase_low  = 1'b0;
    localparam logic [0:0] phase_high = 1'b1;

    if ((fifo_els_p < 2) || ((fifo_els_p & (fifo_els_p - 1)) != 0)) begin : g_bad_depth
        $error("fifo_els_p must be a power of 2 and at least 2");
    end

    logic [0:0]                 phase_r,    phase_n;
    logic [channel_width_p-1:0] low_r,      low_n;
    logic [ptr_w-1:0]           wr_ptr_r,   wr_ptr_n;
    logic [ptr_w-1:0]           rd_ptr_r,   rd_ptr_n;
    logic [cnt_w-1:0]           count_r,    count_n;
    logic [tok_w-1:0]           tok_cnt_r,  tok_cnt_n;
    logic                       token_r,    token_n;
    logic                       overflow_r, overflow_n;

    logic                       word_we;
    logic                       pop_ok;
    logic                       tok_wrap;

    logic [word_w-1:0]          mem_r [fifo_els_p];

    // Next-state: packing phase, FIFO bookkeeping, credit tokens, overflow
    always_comb begin
        phase_n    = phase_r;
        low_n      = low_r;
        wr_ptr_n   = wr_ptr_r;
        rd_ptr_n   = rd_ptr_r;
        count_n    = count_r;
        tok_cnt_n  = tok_cnt_r;
        token_n    = token_r;
        overflow_n = overflow_r;
        word_we    = 1'b0;
        pop_ok     = link_if.core_yumi_i && (count_r != '0);
        tok_wrap   = tok_every_pop || (tok_cnt_r == '1);

        case (phase_r)
            phase_low: begin
                if (link_if.io_valid_i) begin
                    low_n   = link_if.io_data_i;
                    phase_n = phase_high;
                end
            end
            phase_high: begin
                if (link_if.io_valid_i) begin
                    phase_n = phase_low;
                    // A same-cycle pop frees the slot, so a full FIFO still accepts
                    if ((count_r != cnt_full) || pop_ok) begin
                        word_we = 1'b1;
                    end else begin
                        overflow_n = 1'b1;
                    end
                end
            end
            default: phase_n = phase_low;
        endcase

        if (word_we) begin
            wr_ptr_n = wr_ptr_r + ptr_w'(1);
        end

        if (pop_ok) begin
            rd_ptr_n  = rd_ptr_r + ptr_w'(1);
            tok_cnt_n = tok_cnt_r + tok_w'(1);
            if (tok_wrap) begin
                token_n = ~token_r;
            end
        end

        count_n = count_r + cnt_w'(word_we) - cnt_w'(pop_ok);
    end

    // State registers
    always_ff @(posedge io_clk_i or negedge io_link_reset_ni) begin
        if (!io_link_reset_ni) begin
            phase_r    <= phase_low;
            low_r      <= '0;
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            tok_cnt_r  <= '0;
            token_r    <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            phase_r    <= phase_n;
            low_r      <= low_n;
            wr_ptr_r   <= wr_ptr_n;
            rd_ptr_r   <= rd_ptr_n;
            count_r    <= count_n;
            tok_cnt_r  <= tok_cnt_n;
            token_r    <= token_n;
            overflow_r <= overflow_n;
        end
    end

    // Word storage needs no reset; the head is masked while empty
    always_ff @(posedge io_clk_i) begin
        if (word_we) begin
            mem_r[wr_ptr_r] <= {link_if.io_data_i, low_r};
        end
    end

    assign link_if.core_valid_o = (count_r != '0);
    assign link_if.core_data_o  = (count_r != '0) ? mem_r[rd_ptr_r] : '0;
    assign link_if.token_o      = token_r;
    assign link_if.overflow_o   = overflow_r;

endmodule

// File: tb/tb_link_ddr_downstream_unpack.sv
// Bench for link_ddr_downstream_unpack: vector table, directed corner sequences,
// and randomized traffic checked against a queue-based reference model.
module tb_link_ddr_downstream_unpack;

    localparam int unsigned CW    = 16;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned LGD   = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    link_ddr_downstream_unpack_if #(.channel_width_p(CW)) lif ();

    link_ddr_downstream_unpack #(
        .channel_width_p                 (CW),
        .fifo_els_p                      (DEPTH),
        .lg_credit_to_token_decimation_p (LGD)
    ) dut (
        .io_clk_i         (clk),
        .io_link_reset_ni (rst_n),
        .link_if          (lif)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: word queue, packing state, total pops, sticky overflow
    logic [2*CW-1:0] mq [$];
    logic            m_phase;
    logic [CW-1:0]   m_low;
    int              m_pops;
    logic            m_ovf;

    typedef struct {
        logic          v;
        logic [CW-1:0] d;
        logic          y;
        logic          exp_valid;
        logic [31:0]   exp_data;
        logic          exp_token;
        logic          exp_ovf;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [CW-1:0] lo_of(input int k);
        return CW'(16'hA000 + k);
    endfunction

    function automatic logic [CW-1:0] hi_of(input int k);
        return CW'(16'hB000 + k);
    endfunction

    task automatic model_reset();
        mq.delete();
        m_phase = 1'b0;
        m_low   = '0;
        m_pops  = 0;
        m_ovf   = 1'b0;
    endtask

    task automatic check_model();
        chk("valid", 32'(lif.core_valid_o), 32'(mq.size() != 0));
        if (mq.size() != 0) chk("data", lif.core_data_o, mq[0]);
        chk("token", 32'(lif.token_o), 32'((m_pops >> LGD) & 1));
        chk("overflow", 32'(lif.overflow_o), 32'(m_ovf));
    endtask

    // Apply one cycle of stimulus at a falling edge, update the model, check after the edge
    task automatic step(input logic v, input logic [CW-1:0] d, input logic y);
        lif.io_valid_i  = v;
        lif.io_data_i   = d;
        lif.core_yumi_i = y;
        if (y && mq.size() != 0) begin
            mq.delete(0);
            m_pops++;
        end
        if (v && m_phase) begin
            if (mq.size() < DEPTH) mq.push_back({d, m_low});
            else                   m_ovf = 1'b1;
        end
        if (v) begin
            if (!m_phase) m_low = d;
            m_phase = ~m_phase;
        end
        @(posedge clk);
        @(negedge clk);
        check_model();
    endtask

    // Asynchronous reset pulse spanning one rising edge, inputs active during reset
    task automatic do_reset(input logic v, input logic y);
        lif.io_valid_i  = v;
        lif.io_data_i   = '1;
        lif.core_yumi_i = y;
        rst_n = 1'b0;
        #1;
        chk("rst_async_valid", 32'(lif.core_valid_o), 32'd0);
        chk("rst_async_token", 32'(lif.token_o), 32'd0);
        chk("rst_async_ovf",   32'(lif.overflow_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        lif.io_valid_i  = 1'b0;
        lif.io_data_i   = '0;
        lif.core_yumi_i = 1'b0;
        model_reset();
        chk("rst_valid", 32'(lif.core_valid_o), 32'd0);
        chk("rst_token", 32'(lif.token_o), 32'd0);
    endtask

    initial begin
        int toggles;
        logic prev_tok;
        int yprob;

        lif.io_valid_i  = 1'b0;
        lif.io_data_i   = '0;
        lif.core_yumi_i = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset(1'b0, 1'b0);

        // Packing, gapped halves, pops and empty-yumi
        tbl[0] = '{1'b1, 16'h1111, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0};
        tbl[1] = '{1'b1, 16'h2222, 1'b0, 1'b1, 32'h22221111, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 16'h0000, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0};
        tbl[3] = '{1'b1, 16'hAAAA, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0};
        tbl[4] = '{1'b0, 16'h0000, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0};
        tbl[5] = '{1'b0, 16'h0000, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0};
        tbl[6] = '{1'b0, 16'h0000, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0};
        tbl[7] = '{1'b1, 16'hBBBB, 1'b0, 1'b1, 32'hBBBBAAAA, 1'b0, 1'b0};
        tbl[8] = '{1'b0, 16'h0000, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0};
        tbl[9] = '{1'b0, 16'h0000, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0};
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].v, tbl[i].d, tbl[i].y);
            chk($sformatf("tbl%0d_valid", i), 32'(lif.core_valid_o), 32'(tbl[i].exp_valid));
            if (tbl[i].exp_valid) chk($sformatf("tbl%0d_data", i), lif.core_data_o, tbl[i].exp_data);
            chk($sformatf("tbl%0d_token", i), 32'(lif.token_o), 32'(tbl[i].exp_token));
            chk($sformatf("tbl%0d_ovf", i), 32'(lif.overflow_o), 32'(tbl[i].exp_ovf));
        end

        // Fill past depth, drain in order, token decimation
        do_reset(1'b0, 1'b0);
        for (int k = 1; k <= 9; k++) begin
            step(1'b1, lo_of(k), 1'b0);
            step(1'b1, hi_of(k), 1'b0);
        end
        chk("fill_ovf", 32'(lif.overflow_o), 32'd1);
        chk("fill_valid", 32'(lif.core_valid_o), 32'd1);
        toggles  = 0;
        prev_tok = lif.token_o;
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("drain_data%0d", i), lif.core_data_o, {hi_of(i), lo_of(i)});
            step(1'b0, '0, 1'b1);
            if (lif.token_o != prev_tok) toggles++;
            prev_tok = lif.token_o;
            if (i == 3) chk("tok_pop3", 32'(lif.token_o), 32'd0);
            if (i == 4) chk("tok_pop4", 32'(lif.token_o), 32'd1);
            if (i == 8) chk("tok_pop8", 32'(lif.token_o), 32'd0);
        end
        chk("tok_toggles", 32'(toggles), 32'd2);
        chk("drained", 32'(lif.core_valid_o), 32'd0);
        chk("ovf_sticky", 32'(lif.overflow_o), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, 1'b1);
            chk("empty_yumi_tok", 32'(lif.token_o), 32'd0);
        end

        // Full FIFO with a second half and a pop in the same cycle
        do_reset(1'b0, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            step(1'b1, lo_of(k), 1'b0);
            step(1'b1, hi_of(k), 1'b0);
        end
        step(1'b1, lo_of(9), 1'b0);
        step(1'b1, hi_of(9), 1'b1);
        chk("fullpp_ovf", 32'(lif.overflow_o), 32'd0);
        for (int i = 2; i <= 9; i++) begin
            chk($sformatf("fullpp_data%0d", i), lif.core_data_o, {hi_of(i), lo_of(i)});
            step(1'b0, '0, 1'b1);
        end
        chk("fullpp_drained", 32'(lif.core_valid_o), 32'd0);
        chk("fullpp_ovf_end", 32'(lif.overflow_o), 32'd0);

        // Reset with a half-packed word pending
        step(1'b1, 16'h1234, 1'b0);
        do_reset(1'b1, 1'b1);
        step(1'b1, 16'h5555, 1'b0);
        chk("rstmid_valid_lo", 32'(lif.core_valid_o), 32'd0);
        step(1'b1, 16'h6666, 1'b0);
        chk("rstmid_valid", 32'(lif.core_valid_o), 32'd1);
        chk("rstmid_data", lif.core_data_o, 32'h66665555);

        // Randomized traffic with varying consumer rate
        do_reset(1'b0, 1'b0);
        for (int blk = 0; blk < 6; blk++) begin
            yprob = (blk * 37 + 10) % 100;
            if (blk == 3) do_reset(1'b1, 1'b1);
            for (int c = 0; c < 400; c++) begin
                step(1'($urandom_range(0, 3) != 0),
                     CW'($urandom_range(0, 65535)),
                     1'($urandom_range(0, 99) < yprob));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
